// File: rtl/bs_pkg.sv
// Shared types and constants for the Black-Scholes input packet queue.
package bs_pkg;

    localparam int unsigned NUM_FIELDS = 6;
    localparam int unsigned BS_FIELD_W = 32;
    localparam int unsigned PACKET_W   = NUM_FIELDS * BS_FIELD_W;

    // Host packet layout, MSB first; opt_id drops its LSB to make room for otype.
    typedef struct packed {
        logic [BS_FIELD_W-2:0] opt_id;
        logic                  otype;
        logic [BS_FIELD_W-1:0] sptprice;
        logic [BS_FIELD_W-1:0] strike;
        logic [BS_FIELD_W-1:0] rate;
        logic [BS_FIELD_W-1:0] volatility;
        logic [BS_FIELD_W-1:0] time_r;
    } bs_packet_t;

    typedef enum logic {
        BSQ_READY    = 1'b0,
        BSQ_COOLDOWN = 1'b1
    } bs_q_state_t;

endpackage

// File: rtl/bs_packet_queue_fifo.sv
// Power-of-two packet FIFO with occupancy count; flush beats push and pop.
module packet_fifo #(
    parameter int unsigned WIDTH = 192,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push & ~full & ~flush;
        pop_ok   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/bs_packet_queue.sv
// Buffered input stage for the pricing core: queues packets, releases one per
// BS_READY rising edge and holds REG_READY low for COOLDOWN cycles afterwards.
module bs_packet_queue
    import bs_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned FIELD_W  = 32,
    parameter int unsigned COOLDOWN = 50
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [NUM_FIELDS*FIELD_W-1:0] FullPacket,
    input  logic                          flush,
    input  logic                          BS_READY,
    output logic                          in_ready,
    output logic                          dropped,
    output logic                          REG_READY,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [FIELD_W-1:0]            opt_id,
    output logic [FIELD_W-1:0]            sptprice,
    output logic [FIELD_W-1:0]            strike,
    output logic [FIELD_W-1:0]            rate,
    output logic [FIELD_W-1:0]            volatility,
    output logic [FIELD_W-1:0]            time_r,
    output logic [FIELD_W-1:0]            otype
);

    localparam int unsigned PKT_W   = NUM_FIELDS * FIELD_W;
    localparam int unsigned CD_W    = 8;
    localparam int unsigned CD_LAST = (COOLDOWN == 0) ? 0 : COOLDOWN - 1;

    logic [PKT_W-1:0] head;
    logic             full_c, empty_c, rise_c, pop_c;
    logic             prev_bs_q;
    logic             dropped_q, dropped_d;
    bs_q_state_t      state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .push    (en),
        .pop     (pop_c),
        .flush   (flush),
        .wr_data (FullPacket),
        .rd_data (head),
        .count   (count),
        .full    (full_c),
        .empty   (empty_c)
    );

    // Release control: edge detect, cooldown FSM and drop detection.
    always_comb begin
        rise_c    = BS_READY & ~prev_bs_q;
        pop_c     = (state_q == BSQ_READY) & rise_c & ~empty_c & ~flush;
        dropped_d = en & full_c & ~flush;
        state_d   = state_q;
        cd_d      = cd_q;
        if (flush) begin
            state_d = BSQ_READY;
            cd_d    = '0;
        end else begin
            case (state_q)
                BSQ_READY: begin
                    if (pop_c && (COOLDOWN != 0)) begin
                        state_d = BSQ_COOLDOWN;
                        cd_d    = '0;
                    end
                end
                BSQ_COOLDOWN: begin
                    if (cd_q == CD_W'(CD_LAST)) begin
                        state_d = BSQ_READY;
                        cd_d    = '0;
                    end else begin
                        cd_d = cd_q + CD_W'(1);
                    end
                end
                default: begin
                    state_d = BSQ_READY;
                    cd_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BSQ_READY;
            cd_q      <= '0;
            prev_bs_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cd_q      <= cd_d;
            prev_bs_q <= BS_READY;
            dropped_q <= dropped_d;
        end
    end

    // Head operands, forced to zero while the queue is empty.
    always_comb begin
        opt_id     = '0;
        otype      = '0;
        sptprice   = '0;
        strike     = '0;
        rate       = '0;
        volatility = '0;
        time_r     = '0;
        if (!empty_c) begin
            opt_id     = {head[PKT_W-1 -: FIELD_W-1], 1'b0};
            otype      = FIELD_W'(head[PKT_W-FIELD_W]);
            sptprice   = head[5*FIELD_W-1 -: FIELD_W];
            strike     = head[4*FIELD_W-1 -: FIELD_W];
            rate       = head[3*FIELD_W-1 -: FIELD_W];
            volatility = head[2*FIELD_W-1 -: FIELD_W];
            time_r     = head[FIELD_W-1 -: FIELD_W];
        end
    end

    assign REG_READY = (state_q == BSQ_READY) & ~empty_c;
    assign in_ready  = ~full_c;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_bs_packet_queue.sv
// Directed bench for bs_packet_queue: one instance with COOLDOWN=4, one with COOLDOWN=0.
module tb_bs_packet_queue;
    import bs_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    logic         en_a, flush_a, bs_a;
    logic [191:0] pkt_a;
    logic         in_ready_a, dropped_a, reg_ready_a;
    logic [2:0]   count_a;
    logic [31:0]  opt_id_a, sptprice_a, strike_a, rate_a, volatility_a, time_r_a, otype_a;

    logic         en_b, flush_b, bs_b;
    logic [191:0] pkt_b;
    logic         in_ready_b, dropped_b, reg_ready_b;
    logic [2:0]   count_b;
    logic [31:0]  opt_id_b, sptprice_b, strike_b, rate_b, volatility_b, time_r_b, otype_b;

    always #5 clock = ~clock;

    bs_packet_queue #(.DEPTH(4), .FIELD_W(32), .COOLDOWN(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .en(en_a), .FullPacket(pkt_a), .flush(flush_a),
        .BS_READY(bs_a), .in_ready(in_ready_a), .dropped(dropped_a), .REG_READY(reg_ready_a),
        .count(count_a), .opt_id(opt_id_a), .sptprice(sptprice_a), .strike(strike_a),
        .rate(rate_a), .volatility(volatility_a), .time_r(time_r_a), .otype(otype_a)
    );

    bs_packet_queue #(.DEPTH(4), .FIELD_W(32), .COOLDOWN(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .en(en_b), .FullPacket(pkt_b), .flush(flush_b),
        .BS_READY(bs_b), .in_ready(in_ready_b), .dropped(dropped_b), .REG_READY(reg_ready_b),
        .count(count_b), .opt_id(opt_id_b), .sptprice(sptprice_b), .strike(strike_b),
        .rate(rate_b), .volatility(volatility_b), .time_r(time_r_b), .otype(otype_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bs_packet_t mkpkt(input int unsigned i);
        bs_packet_t p;
        p.opt_id     = 31'(32'h100 + i);
        p.otype      = i[0];
        p.sptprice   = 32'hA000_0000 + i;
        p.strike     = 32'hB000_0000 + i;
        p.rate       = 32'hC000_0000 + i;
        p.volatility = 32'hD000_0000 + i;
        p.time_r     = 32'hE000_0000 + i;
        return p;
    endfunction

    initial begin
        logic [191:0] p0;
        p0      = 192'h12345679_3F800000_3F8CCCCD_40000000_40400000_40000000;
        reset_n = 1'b0;
        en_a = 1'b0; flush_a = 1'b0; bs_a = 1'b0; pkt_a = '0;
        en_b = 1'b0; flush_b = 1'b0; bs_b = 1'b0; pkt_b = '0;
        #1;
        check("rst_reg_ready", 32'(reg_ready_a), 0);
        check("rst_in_ready", 32'(in_ready_a), 1);
        check("rst_count", 32'(count_a), 0);
        check("rst_dropped", 32'(dropped_a), 0);
        check("rst_opt_id", opt_id_a, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Single push and unpack
        pkt_a = p0; en_a = 1'b1; tick(); en_a = 1'b0;
        check("push_reg_ready", 32'(reg_ready_a), 1);
        check("push_opt_id", opt_id_a, 32'h12345678);
        check("push_otype", otype_a, 1);
        check("push_sptprice", sptprice_a, 32'h3F800000);
        check("push_strike", strike_a, 32'h3F8CCCCD);
        check("push_rate", rate_a, 32'h40000000);
        check("push_volatility", volatility_a, 32'h40400000);
        check("push_time_r", time_r_a, 32'h40000000);
        check("push_count", 32'(count_a), 1);

        // Release with cooldown of 4; toggles during cooldown are ignored
        pkt_a = mkpkt(1); en_a = 1'b1; tick(); en_a = 1'b0;
        check("cd_count2", 32'(count_a), 2);
        check("cd_head_p0", opt_id_a, 32'h12345678);
        bs_a = 1'b1; tick();
        check("cd_low1", 32'(reg_ready_a), 0);
        check("cd_pop_count", 32'(count_a), 1);
        bs_a = 1'b0; tick(); check("cd_low2", 32'(reg_ready_a), 0);
        bs_a = 1'b1; tick(); check("cd_low3", 32'(reg_ready_a), 0);
        bs_a = 1'b0; tick(); check("cd_low4", 32'(reg_ready_a), 0);
        tick();
        check("cd_high", 32'(reg_ready_a), 1);
        check("cd_count_kept", 32'(count_a), 1);
        check("cd_second_opt", opt_id_a, 32'h202);
        check("cd_second_spt", sptprice_a, 32'hA000_0001);
        tick();
        check("cd_no_queued_rise", 32'(count_a), 1);
        bs_a = 1'b1; tick(); bs_a = 1'b0;
        check("cd_drain_count", 32'(count_a), 0);
        check("cd_drain_opt", opt_id_a, 0);
        check("cd_drain_ready", 32'(reg_ready_a), 0);
        repeat (4) tick();

        // Rise while empty must not start a cooldown
        bs_a = 1'b1; tick(); bs_a = 1'b0;
        check("empty_rise_count", 32'(count_a), 0);
        pkt_a = p0; en_a = 1'b1; tick(); en_a = 1'b0;
        check("empty_rise_no_cd", 32'(reg_ready_a), 1);

        // Overfill by one, then drain in order (COOLDOWN=0 instance)
        for (int i = 0; i < 5; i++) begin
            pkt_b = mkpkt(i); en_b = 1'b1; tick();
            check($sformatf("fill_in_ready_%0d", i), 32'(in_ready_b), 32'(i < 3));
            check($sformatf("fill_dropped_%0d", i), 32'(dropped_b), 32'(i == 4));
            check($sformatf("fill_count_%0d", i), 32'(count_b), (i < 4) ? i + 1 : 4);
        end
        en_b = 1'b0; tick();
        check("fill_dropped_clear", 32'(dropped_b), 0);
        check("fill_count_final", 32'(count_b), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_ready_%0d", k), 32'(reg_ready_b), 1);
            check($sformatf("drain_opt_%0d", k), opt_id_b, (32'h100 + k) << 1);
            check($sformatf("drain_spt_%0d", k), sptprice_b, 32'hA000_0000 + k);
            check($sformatf("drain_otype_%0d", k), otype_b, k & 1);
            bs_b = 1'b1; tick(); bs_b = 1'b0; tick();
        end
        check("drain_empty_count", 32'(count_b), 0);
        check("drain_empty_ready", 32'(reg_ready_b), 0);
        check("drain_empty_opt", opt_id_b, 0);
        check("drain_empty_spt", sptprice_b, 0);
        check("drain_empty_time", time_r_b, 0);

        // Same-cycle push and release: full rejects, partial keeps count
        for (int i = 0; i < 4; i++) begin
            pkt_b = mkpkt(10 + i); en_b = 1'b1; tick();
        end
        en_b = 1'b0;
        check("full_count", 32'(count_b), 4);
        check("full_in_ready", 32'(in_ready_b), 0);
        pkt_b = mkpkt(14); en_b = 1'b1; bs_b = 1'b1; tick(); en_b = 1'b0; bs_b = 1'b0;
        check("full_pp_dropped", 32'(dropped_b), 1);
        check("full_pp_count", 32'(count_b), 3);
        check("full_pp_head", opt_id_b, 32'h216);
        tick();
        check("full_pp_dropped_clear", 32'(dropped_b), 0);
        bs_b = 1'b1; tick(); bs_b = 1'b0; tick();
        check("mid_count", 32'(count_b), 2);
        pkt_b = mkpkt(15); en_b = 1'b1; bs_b = 1'b1; tick(); en_b = 1'b0; bs_b = 1'b0;
        check("mid_pp_count", 32'(count_b), 2);
        check("mid_pp_dropped", 32'(dropped_b), 0);

        // COOLDOWN=0: releases on every rise of a toggling BS_READY
        pkt_b = mkpkt(16); en_b = 1'b1; tick(); en_b = 1'b0;
        check("tog_count3", 32'(count_b), 3);
        for (int j = 0; j < 6; j++) begin
            bs_b = (j % 2 == 0); tick();
            check($sformatf("tog_count_%0d", j), 32'(count_b), 2 - j / 2);
        end
        bs_b = 1'b1; tick(); bs_b = 1'b0;
        check("tog_empty_count", 32'(count_b), 0);
        check("tog_empty_ready", 32'(reg_ready_b), 0);

        // Flush in the middle of a cooldown
        pkt_a = mkpkt(20); en_a = 1'b1; tick(); en_a = 1'b0;
        bs_a = 1'b1; tick(); bs_a = 1'b0;
        check("fl_pop_count", 32'(count_a), 1);
        check("fl_in_cd", 32'(reg_ready_a), 0);
        tick();
        flush_a = 1'b1; en_a = 1'b1; tick(); flush_a = 1'b0; en_a = 1'b0;
        check("fl_count", 32'(count_a), 0);
        check("fl_dropped", 32'(dropped_a), 0);
        check("fl_opt", opt_id_a, 0);
        pkt_a = p0; en_a = 1'b1; tick(); en_a = 1'b0;
        check("fl_state_ready", 32'(reg_ready_a), 1);
        check("fl_push_count", 32'(count_a), 1);
        pkt_a = mkpkt(21); en_a = 1'b1; tick(); en_a = 1'b0;
        check("fl_count2", 32'(count_a), 2);

        // Asynchronous reset between clock edges
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count_a), 0);
        check("arst_ready", 32'(reg_ready_a), 0);
        check("arst_in_ready", 32'(in_ready_a), 1);
        check("arst_opt", opt_id_a, 0);
        check("arst_dropped", 32'(dropped_a), 0);
        check("arst_count_b", 32'(count_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
